// File: rtl/alu_pkg.sv
// Shared ALU control codes and sequencer state encodings.
// The ALU datapath imports the same codes.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;
  localparam logic [3:0] ALU_DIV  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } seq_state_t;

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU control decode from main-control op class and
// instruction fields; flags RV32M multiply/divide when enabled.
module alu_decode
  import alu_pkg::*;
#(
  parameter int MD_EN = 1
) (
  input  logic [1:0] aluOp,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       op,
  output logic [3:0] code,
  output logic       isMd,
  output logic       isDiv
);

  logic mPattern;

  assign mPattern = (aluOp == 2'b10) && op && (funct7 == 7'b0000001);

  always_comb begin
    code  = ALU_ADD;
    isMd  = 1'b0;
    isDiv = 1'b0;
    case (aluOp)
      2'b00: code = ALU_ADD;
      2'b01: code = ALU_SUB;
      2'b11: code = ALU_ADD;
      default: begin
        // With M disabled, M-extension encodings fall back to add.
        if (mPattern) begin
          if (MD_EN != 0) begin
            isMd  = 1'b1;
            isDiv = funct3[2];
            code  = funct3[2] ? ALU_DIV : ALU_MUL;
          end else begin
            code = ALU_ADD;
          end
        end else begin
          case (funct3)
            3'b000:  code = (op && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_decode_sequencer.sv
// Registered ALU control with a small FSM that holds off upstream while a
// multi-cycle multiply or divide occupies the datapath.
module alu_decode_sequencer
  import alu_pkg::*;
#(
  parameter int CTRL_W  = 4,
  parameter int MD_EN   = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              inValid,
  input  logic [1:0]        aluOp,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              op,
  output logic [CTRL_W-1:0] aluControl,
  output logic              outValid,
  output logic              mdStart,
  output logic              mdIsDiv,
  output logic              busy
);

  localparam int CNT_W = $clog2(maxOf(MUL_LAT, DIV_LAT) + 1);

  logic [3:0]       decCode;
  logic             decIsMd;
  logic             decIsDiv;
  logic [CNT_W-1:0] lat;
  logic [CNT_W-1:0] count;
  logic             accept;
  seq_state_t       state;

  alu_decode #(.MD_EN(MD_EN)) u_decode (
    .aluOp  (aluOp),
    .funct3 (funct3),
    .funct7 (funct7),
    .op     (op),
    .code   (decCode),
    .isMd   (decIsMd),
    .isDiv  (decIsDiv)
  );

  assign accept = inValid && !busy;
  assign lat    = decIsDiv ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

  // outValid is raised one edge early (count==2) so it lines up with the
  // cycle in which the counter reads 1, which is also the last busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      aluControl <= '0;
      outValid   <= 1'b0;
      mdStart    <= 1'b0;
      mdIsDiv    <= 1'b0;
      busy       <= 1'b0;
      state      <= IDLE;
      count      <= '0;
    end else if (flush) begin
      outValid <= 1'b0;
      mdStart  <= 1'b0;
      busy     <= 1'b0;
      state    <= IDLE;
      count    <= '0;
    end else begin
      outValid <= 1'b0;
      mdStart  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            aluControl <= CTRL_W'(decCode);
            mdIsDiv    <= decIsDiv;
            if (decIsMd) begin
              state    <= decIsDiv ? DIV_BUSY : MUL_BUSY;
              busy     <= 1'b1;
              mdStart  <= 1'b1;
              count    <= lat;
              outValid <= (lat == CNT_W'(1));
            end else begin
              outValid <= 1'b1;
            end
          end
        end
        MUL_BUSY, DIV_BUSY: begin
          if (count <= CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else begin
            count    <= count - CNT_W'(1);
            outValid <= (count == CNT_W'(2));
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_decode_sequencer.sv
// Directed bench for alu_decode_sequencer: decode table, mul/div timing,
// flush and reset aborts, and the MD_EN=0 fallback.
module tb_alu_decode_sequencer;

  logic       clk = 1'b0;
  logic       reset, flush, inValid, op;
  logic [1:0] aluOp;
  logic [2:0] funct3;
  logic [6:0] funct7;

  logic [3:0] aluControl, aluControl0;
  logic       outValid, mdStart, mdIsDiv, busy;
  logic       outValid0, mdStart0, mdIsDiv0, busy0;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string      name;
    logic [1:0] aluOp;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       op;
    logic [3:0] expCode;
  } vec_t;

  vec_t vecs[15];

  always #5 clk = ~clk;

  alu_decode_sequencer dut (
    .clk(clk), .reset(reset), .flush(flush), .inValid(inValid),
    .aluOp(aluOp), .funct3(funct3), .funct7(funct7), .op(op),
    .aluControl(aluControl), .outValid(outValid), .mdStart(mdStart),
    .mdIsDiv(mdIsDiv), .busy(busy)
  );

  alu_decode_sequencer #(.MD_EN(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .inValid(inValid),
    .aluOp(aluOp), .funct3(funct3), .funct7(funct7), .op(op),
    .aluControl(aluControl0), .outValid(outValid0), .mdStart(mdStart0),
    .mdIsDiv(mdIsDiv0), .busy(busy0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] a, input logic [2:0] f3,
                               input logic [6:0] f7, input logic o);
    inValid = v;
    aluOp   = a;
    funct3  = f3;
    funct7  = f7;
    op      = o;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic sawBad;

    vecs[0]  = '{"sub_rtype",  2'b10, 3'b000, 7'b0100000, 1'b1, 4'b0001};
    vecs[1]  = '{"addi",       2'b10, 3'b000, 7'b0100000, 1'b0, 4'b0000};
    vecs[2]  = '{"srai",       2'b10, 3'b101, 7'b0100000, 1'b0, 4'b1001};
    vecs[3]  = '{"srl",        2'b10, 3'b101, 7'b0000000, 1'b1, 4'b1000};
    vecs[4]  = '{"sll",        2'b10, 3'b001, 7'b0000000, 1'b1, 4'b0111};
    vecs[5]  = '{"slt",        2'b10, 3'b010, 7'b0000000, 1'b1, 4'b0101};
    vecs[6]  = '{"sltu",       2'b10, 3'b011, 7'b0000000, 1'b1, 4'b0110};
    vecs[7]  = '{"xor",        2'b10, 3'b100, 7'b0000000, 1'b1, 4'b0100};
    vecs[8]  = '{"or",         2'b10, 3'b110, 7'b0000000, 1'b1, 4'b0011};
    vecs[9]  = '{"and",        2'b10, 3'b111, 7'b0000000, 1'b1, 4'b0010};
    vecs[10] = '{"aluop00",    2'b00, 3'b111, 7'b0100000, 1'b1, 4'b0000};
    vecs[11] = '{"aluop01",    2'b01, 3'b110, 7'b0000000, 1'b0, 4'b0001};
    vecs[12] = '{"aluop11",    2'b11, 3'b101, 7'b0100000, 1'b1, 4'b0000};
    vecs[13] = '{"add_rtype",  2'b10, 3'b000, 7'b0000000, 1'b1, 4'b0000};
    vecs[14] = '{"xori_f7m",   2'b10, 3'b100, 7'b0000001, 1'b0, 4'b0100};

    reset = 1'b1;
    flush = 1'b0;
    applyStimulus(1'b1, 2'b10, 3'b100, 7'b0000001, 1'b1);
    step();
    step();
    checkOutput("reset_outs", {aluControl, outValid, mdStart, mdIsDiv, busy}, 32'h0);
    reset = 1'b0;
    applyStimulus(1'b0, 2'b00, 3'b000, 7'b0, 1'b0);
    step();
    checkOutput("idle_outvalid", outValid, 0);

    // Back-to-back single-cycle ops, one accept per cycle.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b1, vecs[i].aluOp, vecs[i].funct3, vecs[i].funct7, vecs[i].op);
      step();
      checkOutput({vecs[i].name, "_code"}, aluControl, vecs[i].expCode);
      checkOutput({vecs[i].name, "_valid_busy"}, {outValid, busy, mdStart}, 3'b100);
    end
    applyStimulus(1'b0, 2'b00, 3'b000, 7'b0, 1'b0);
    step();
    checkOutput("single_valid_drop", outValid, 0);

    // Multiply, MUL_LAT=3.
    applyStimulus(1'b1, 2'b10, 3'b000, 7'b0000001, 1'b1);
    step();
    checkOutput("mul_c1", {aluControl, mdIsDiv, mdStart, busy, outValid}, {4'b1010, 4'b0110});
    applyStimulus(1'b0, 2'b00, 3'b000, 7'b0, 1'b0);
    step();
    checkOutput("mul_c2", {mdStart, busy, outValid}, 3'b010);
    step();
    checkOutput("mul_c3", {mdStart, busy, outValid}, 3'b011);
    step();
    checkOutput("mul_c4", {mdStart, busy, outValid}, 3'b000);

    // Divide with inValid held high: the next accept lands in cycle 33.
    applyStimulus(1'b1, 2'b10, 3'b100, 7'b0000001, 1'b1);
    for (int k = 1; k <= 34; k++) begin
      logic [2:0] exp;
      step();
      if (k <= 32) exp = {(k == 1), 1'b1, (k == 32)};
      else if (k == 33) exp = 3'b000;
      else exp = 3'b110;
      checkOutput($sformatf("div_held_c%0d", k), {mdStart, busy, outValid}, exp);
    end
    checkOutput("div_code", {aluControl, mdIsDiv}, {4'b1011, 1'b1});

    // Second divide is in its cycle 1; flush it during cycle 10.
    applyStimulus(1'b0, 2'b00, 3'b000, 7'b0, 1'b0);
    sawBad = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      step();
      if (outValid || !busy) sawBad = 1'b1;
    end
    checkOutput("div_pre_flush", sawBad, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("div_flushed", {aluControl, mdStart, busy, outValid}, {4'b1011, 3'b000});
    sawBad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (outValid || busy) sawBad = 1'b1;
    end
    checkOutput("div_flush_no_valid", sawBad, 0);

    // Flush beats a same-cycle valid input; aluControl holds.
    applyStimulus(1'b1, 2'b10, 3'b111, 7'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 2'b00, 3'b000, 7'b0, 1'b0);
    checkOutput("flush_wins", {aluControl, outValid, busy}, {4'b1011, 2'b00});

    // Reset in the middle of a multiply.
    applyStimulus(1'b1, 2'b10, 3'b001, 7'b0000001, 1'b1);
    step();
    applyStimulus(1'b0, 2'b00, 3'b000, 7'b0, 1'b0);
    step();
    checkOutput("mul_pre_reset_busy", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("mul_reset_outs", {aluControl, outValid, mdStart, mdIsDiv, busy}, 32'h0);
    sawBad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (outValid || busy) sawBad = 1'b1;
    end
    checkOutput("mul_reset_no_valid", sawBad, 0);

    // MD_EN=0 instance treats an M encoding as add.
    applyStimulus(1'b1, 2'b10, 3'b000, 7'b0000001, 1'b1);
    step();
    applyStimulus(1'b0, 2'b00, 3'b000, 7'b0, 1'b0);
    checkOutput("mden0_code", aluControl0, 4'b0000);
    checkOutput("mden0_flags", {outValid0, busy0, mdStart0, mdIsDiv0}, 4'b1000);
    checkOutput("mden1_is_mul", {aluControl, mdStart}, {4'b1010, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
